// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package tt_sweep_pkg;
  localparam int N_IN_DEF   = 3;
  localparam int N_OUT_DEF  = 8;
  localparam int SETTLE_DEF = 1;
  localparam int N_VEC      = 2 ** N_IN_DEF;
  localparam int IDX_W      = $clog2(N_OUT_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width helper that never returns 0, so single-entry ranges stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tt_capture_matrix.sv
// N_OUT x NV capture array: one write port per sampled vector, a column read mux
// and all-zero / all-one reducers looking at the matrix including the pending write.
module tt_capture_matrix
  import tt_sweep_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int VEC_W = N_IN_DEF,
  parameter int NV    = N_VEC,
  parameter int IW    = IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [VEC_W-1:0] wr_vec,
  input  logic [N_OUT-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [NV-1:0]    rd_data,
  output logic [N_OUT-1:0] all0,
  output logic [N_OUT-1:0] all1
);
  logic [N_OUT-1:0][NV-1:0] mat;
  logic [N_OUT-1:0][NV-1:0] mat_nx;

  always_comb begin
    mat_nx = mat;
    if (wr_en) begin
      for (int k = 0; k < N_OUT; k++) mat_nx[k][wr_vec] = wr_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mat <= '0;
    else if (wr_en) mat <= mat_nx;
  end

  // Reducers see the write in flight so the final sample lands in the masks.
  for (genvar k = 0; k < N_OUT; k++) begin : g_red
    assign all0[k] = ~|mat_nx[k];
    assign all1[k] = &mat_nx[k];
  end

  if (N_OUT == 2 ** IW) begin : g_rd_full
    assign rd_data = mat[rd_idx];
  end else begin : g_rd_guard
    assign rd_data = (int'(rd_idx) < N_OUT) ? mat[rd_idx] : '0;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a combinational DUT, captures its outputs and
// streams one truth-table column per output with constant-0/1 flags.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int  N_IN          = N_IN_DEF,
  parameter int  N_OUT         = N_OUT_DEF,
  parameter int  SETTLE_CYCLES = SETTLE_DEF,
  localparam int NV            = 2 ** N_IN,
  localparam int IW            = clog2_min1(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [IW-1:0]    tt_index,
  output logic [NV-1:0]    tt_data,
  output logic [N_OUT-1:0] const0_mask,
  output logic [N_OUT-1:0] const1_mask
);
  localparam int SW = clog2_min1(SETTLE_CYCLES + 1);

  localparam logic [1:0]    ST_IDLE  = IDLE;
  localparam logic [1:0]    ST_SWEEP = SWEEP;
  localparam logic [1:0]    ST_EMIT  = EMIT;
  localparam logic [1:0]    ST_DONE  = DONE;
  localparam logic [SW-1:0] SET_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [N_IN:0] VEC_LAST = (N_IN + 1)'(NV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);

  logic [1:0]       state;
  logic [N_IN:0]    vec;
  logic [SW-1:0]    settle;
  logic             sample;
  logic [N_OUT-1:0] all0;
  logic [N_OUT-1:0] all1;
  logic [NV-1:0]    col;

  assign sample = (state == ST_SWEEP) && (settle == SET_MAX);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign dut_x  = vec[N_IN-1:0];
  assign tt_data = tt_valid ? col : '0;

  tt_capture_matrix #(
    .N_OUT(N_OUT),
    .VEC_W(N_IN),
    .NV   (NV),
    .IW   (IW)
  ) u_mat (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (sample),
    .wr_vec (vec[N_IN-1:0]),
    .wr_data(dut_f),
    .rd_idx (tt_index),
    .rd_data(col),
    .all0   (all0),
    .all1   (all1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vec         <= '0;
      settle      <= '0;
      tt_valid    <= 1'b0;
      tt_index    <= '0;
      const0_mask <= '0;
      const1_mask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_SWEEP;
            vec    <= '0;
            settle <= '0;
          end
        end
        ST_SWEEP: begin
          if (sample) begin
            settle <= '0;
            if (vec == VEC_LAST) begin
              // The extra counter bit is never needed: dut_x returns to 0 here.
              vec         <= '0;
              state       <= ST_EMIT;
              tt_valid    <= 1'b1;
              tt_index    <= '0;
              const0_mask <= all0;
              const1_mask <= all1;
            end else begin
              vec <= vec + 1'b1;
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        ST_EMIT: begin
          if (tt_ready) begin
            if (tt_index == IDX_LAST) begin
              state    <= ST_DONE;
              tt_valid <= 1'b0;
              tt_index <= '0;
            end else begin
              tt_index <= tt_index + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: instance a (SETTLE_CYCLES=1) and b (SETTLE_CYCLES=3, DUT delayed 2 cycles).
module tb_truth_table_sweeper;
  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  // Hand-derived columns of the bench DUT model below (bit v = f at x==v).
  localparam logic [7:0] EXP_COL [8] = '{8'h66, 8'h01, 8'hFF, 8'hFF, 8'hF0, 8'hAA, 8'hC0, 8'hFF};

  logic       clk;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] ready;
  logic       zero;
  logic [1:0] busy, done, valid;
  logic [2:0] x    [2];
  logic [2:0] idx  [2];
  logic [7:0] data [2];
  logic [7:0] c0   [2];
  logic [7:0] c1   [2];
  logic [7:0] f_a, f_b, d1, d2;

  int   total = 0;
  int   bad   = 0;
  int   hs    [2] = '{0, 0};
  logic pstall[2] = '{1'b0, 1'b0};
  logic [2:0] pidx  [2];
  logic [7:0] pdata [2];
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [7:0] model(input logic [2:0] v);
    logic [7:0] f;
    f[0] = v[0] ^ v[1];
    f[1] = ~(v[0] | v[1] | v[2]);
    f[2] = 1'b1;
    f[3] = 1'b1;
    f[4] = v[2];
    f[5] = v[0];
    f[6] = v[1] & v[2];
    f[7] = 1'b1;
    return f;
  endfunction

  assign f_a = zero ? 8'h00 : model(x[0]);
  always @(posedge clk) begin
    d1 <= model(x[1]);
    d2 <= d1;
  end
  assign f_b = d2;

  truth_table_sweeper u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .dut_x(x[0]), .dut_f(f_a), .tt_valid(valid[0]), .tt_ready(ready[0]),
    .tt_index(idx[0]), .tt_data(data[0]), .const0_mask(c0[0]), .const1_mask(c1[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .dut_x(x[1]), .dut_f(f_b), .tt_valid(valid[1]), .tt_ready(ready[1]),
    .tt_index(idx[1]), .tt_data(data[1]), .const0_mask(c0[1]), .const1_mask(c1[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-stability on stalls.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (pstall[s]) begin
        chk("stall_idx", idx[s], pidx[s]);
        chk("stall_data", data[s], pdata[s]);
      end
      if (valid[s] && ready[s]) begin
        if ((s == 0 ? q0.size() : q1.size()) == 0) begin
          chk("unexpected_col", 1, 0);
        end else begin
          if (s == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("col_idx", idx[s], e.idx);
          chk("col_data", data[s], e.data);
          hs[s] <= hs[s] + 1;
        end
      end
      pstall[s] <= valid[s] && !ready[s];
      pidx[s]   <= idx[s];
      pdata[s]  <= data[s];
    end
  end

  task automatic push_exp(input int s, input bit zr);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.idx  = 3'(k);
      e.data = zr ? 8'h00 : EXP_COL[k];
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_busy", busy[s], 0);
    chk("rst_done", done[s], 0);
    chk("rst_x", x[s], 0);
    chk("rst_valid", valid[s], 0);
    chk("rst_idx", idx[s], 0);
    chk("rst_data", data[s], 0);
    chk("rst_c0", c0[s], 0);
    chk("rst_c1", c1[s], 0);
  endtask

  // Leaves the bench 1 time unit after edge E0 with start still high.
  task automatic issue_start(input int s);
    @(posedge clk); #1;
    start[s] = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs from just after E0 until one cycle past the done pulse.
  task automatic collect(input int s, input bit stall, input bit zr);
    int n, fv, dn, h0, lat;
    n = 0; fv = -1; dn = -1; h0 = hs[s];
    lat = (s == 0) ? 16 : 32;
    ready[s] = !stall;
    while (n < 400 && dn < 0) begin
      @(posedge clk); #1;
      n++;
      if (valid[s] && fv < 0) fv = n;
      if (stall && fv >= 0) ready[s] = (n >= fv + 5) ? !ready[s] : 1'b0;
      if (done[s]) dn = n;
    end
    chk("first_valid", fv, lat);
    if (!stall) chk("done_edge", dn, lat + 8);
    chk("handshakes", hs[s] - h0, 8);
    chk("const0", c0[s], zr ? 8'hFF : 8'h00);
    chk("const1", c1[s], zr ? 8'h00 : 8'h8C);
    chk("x_after", x[s], 0);
    chk("busy_in_done", busy[s], 1);
    @(posedge clk); #1;
    chk("done_pulse", done[s], 0);
    chk("idle", busy[s], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clk = 1'b0; rst_n = 1'b0; start = '0; ready = '0; zero = 1'b0;
    #3;
    chk_reset(0);
    chk_reset(1);
    #9 rst_n = 1'b1;

    // Plain sweep, consumer always ready
    push_exp(0, 0); issue_start(0); start[0] = 1'b0;
    collect(0, 0, 0);

    // Back-pressure: 5 stalled cycles at k=0, then alternating ready
    push_exp(0, 0); issue_start(0); start[0] = 1'b0;
    collect(0, 1, 0);

    // start held through the sweep and DONE: one sweep, then a new one from IDLE
    push_exp(0, 0); issue_start(0);
    collect(0, 0, 0);
    push_exp(0, 0);
    @(posedge clk); #1;
    chk("held_start_restart", busy[0], 1);
    start[0] = 1'b0;
    collect(0, 0, 0);

    // All-zero DUT
    zero = 1'b1;
    push_exp(0, 1); issue_start(0); start[0] = 1'b0;
    collect(0, 0, 1);
    zero = 1'b0;

    // Async reset mid-sweep at vector 5, then a clean rerun
    push_exp(0, 0); issue_start(0); start[0] = 1'b0;
    n = 0;
    while (x[0] != 3'd5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec5", x[0], 5);
    #2 rst_n = 1'b0;
    #1 chk_reset(0);
    q0.delete();
    #2 rst_n = 1'b1;
    push_exp(0, 0); issue_start(0); start[0] = 1'b0;
    collect(0, 0, 0);

    // Longer settle window against a DUT with 2 cycles of output delay
    push_exp(1, 0); issue_start(1); start[1] = 1'b0;
    collect(1, 0, 0);

    chk("queue_empty", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
